// File: rtl/cnn_pkg.sv
// Shared types for the CNN accelerator datapath.
// Word/address widths, DMA FSM states and the DMA command bundle.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;
  localparam int CNN_ADDR_WIDTH = 16;
  localparam int CNN_MAX_BURST  = 25;
  localparam int CNN_LEN_WIDTH  = $clog2(CNN_MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } dma_state_e;

  typedef struct packed {
    logic                      rw;
    logic [CNN_ADDR_WIDTH-1:0] addr;
    logic [CNN_LEN_WIDTH-1:0]  len;
  } dma_cmd_t;

endpackage

// File: rtl/dma_skid_buffer.sv
// Two-entry valid/ready register slice with registered outputs.
// Entry 0 drives the output; entry 1 absorbs a word while stalled.
module dma_skid_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] d0, d1;
  logic                  v0, v1;
  logic                  pop;

  // output view and occupancy (v1 implies v0)
  always_comb begin
    out_valid = v0;
    out_data  = d0;
    level     = {v1, v0 & ~v1};
    pop       = v0 && out_ready;
  end

  // shift on pop, fill the lowest free entry on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (pop) begin
      if (v1) begin
        d0 <= d1;
        if (in_valid) d1 <= in_data;
        else          v1 <= 1'b0;
      end else if (in_valid) begin
        d0 <= in_data;
      end else begin
        v0 <= 1'b0;
      end
    end else if (in_valid) begin
      if (!v0) begin
        d0 <= in_data;
        v0 <= 1'b1;
      end else begin
        d1 <= in_data;
        v1 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_burst_engine.sv
// Burst read/write engine around the on-chip word RAM.
// One command at a time; reads stream through a skid buffer.
module dma_burst_engine
  import cnn_pkg::*;
#(
  parameter int    DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int    ADDR_WIDTH = CNN_ADDR_WIDTH,
  parameter int    MEM_DEPTH  = 2500,
  parameter int    MAX_BURST  = CNN_MAX_BURST,
  parameter int    LEN_WIDTH  = $clog2(MAX_BURST + 1),
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [LEN_WIDTH-1:0]  MAX_L   = LEN_WIDTH'(MAX_BURST);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  dma_state_e            state, state_nx;
  dma_cmd_t              cmd_in;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [LEN_WIDTH-1:0]  len_q, beat_q, iss_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_vld;
  logic [1:0]            lvl;
  logic [2:0]            occ;
  logic                  acc, bad, pop;
  logic                  rd_issue, wr_beat;
  logic                  last_beat;

  // command decode, wrapping address step, skid occupancy
  always_comb begin
    cmd_in    = '{rw: cmd_rw, addr: cmd_addr, len: cmd_len};
    bad       = (cmd_in.len > MAX_L) || (cmd_in.addr >= DEPTH_A);
    addr_nx   = (addr_q == LAST_A) ? '0 : addr_q + ADDR_WIDTH'(1);
    last_beat = (beat_q + LEN_WIDTH'(1)) == len_q;
    pop       = rd_valid && rd_ready;
    occ       = 3'(lvl) + 3'(ram_vld);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc && !bad) begin
          if (cmd_in.len == '0) state_nx = FIN;
          else if (cmd_in.rw)   state_nx = RD;
          else                  state_nx = WR;
        end
      end
      RD:  if (pop && last_beat)     state_nx = FIN;
      WR:  if (wr_beat && last_beat) state_nx = FIN;
      FIN: state_nx = IDLE;
    endcase
  end

  // FSM outputs; a read issues only if the skid slot is free when it lands
  always_comb begin
    cmd_ready = (state == IDLE);
    wr_ready  = (state == WR);
    acc       = cmd_valid && cmd_ready;
    wr_beat   = wr_ready && wr_valid;
    rd_issue  = (state == RD) && (iss_q != len_q) &&
                (occ < (3'd2 + 3'(pop)));
  end

  // counters, status pulses and read-pipeline valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      iss_q   <= '0;
      ram_vld <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= (state == FIN);
      err     <= acc && bad;
      ram_vld <= rd_issue;
      if (acc && !bad) begin
        addr_q <= cmd_in.addr;
        len_q  <= cmd_in.len;
        beat_q <= '0;
        iss_q  <= '0;
      end else begin
        if (rd_issue || wr_beat) addr_q <= addr_nx;
        if (rd_issue)            iss_q  <= iss_q + LEN_WIDTH'(1);
        if (pop || wr_beat)      beat_q <= beat_q + LEN_WIDTH'(1);
      end
    end
  end

  // word RAM: contents survive reset
  always_ff @(posedge clk) begin
    if (wr_beat)  mem[addr_q[IDX_W-1:0]] <= wr_data;
    if (rd_issue) ram_q <= mem[addr_q[IDX_W-1:0]];
  end

  dma_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ram_vld),
    .in_data   (ram_q),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .out_ready (rd_ready),
    .level     (lvl)
  );

endmodule
